// File: rtl/marcador_vidas_pkg.sv
// Shared definitions for the score/lives tracker: state encoding and counter widths.
package marcador_vidas_pkg;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    JUGANDO = 2'd1,
    PERDIDO = 2'd2
  } estado_t;

  localparam int RACHA_W = 8;
  localparam int VIDAS_W = 3;

  localparam logic [RACHA_W-1:0] RACHA_MAX = '1;

endpackage

// File: rtl/marcador_vidas_detector_flanco.sv
// Synchronous rising-edge detector; the pulse is registered, so it trails the input edge by one clock.
module detector_flanco (
  input  logic clk,
  input  logic reset,
  input  logic i_in,
  output logic o_pulse
);

  logic r_q;
  logic r_pulse;

  // r_q clears on reset, so a level already high at release still yields one pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q     <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_q     <= i_in;
      r_pulse <= i_in & ~r_q;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/marcador_vidas.sv
// Score, combo and lives tracker for one level; raises Perdio when lives run out and freezes while Stop is high.
module marcador_vidas
  import marcador_vidas_pkg::*;
#(
  parameter int VIDAS_INI   = 3,
  parameter int SCORE_W     = 16,
  parameter int PUNTOS_BASE = 10,
  parameter int COMBO_PASO  = 4,
  parameter int MULT_MAX    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Iniciar,
  input  logic               Stop,
  input  logic               Acierto,
  input  logic               Fallo,
  output logic               Perdio,
  output logic [SCORE_W-1:0] Puntaje,
  output logic [VIDAS_W-1:0] Vidas,
  output logic [2:0]         Mult,
  output logic [RACHA_W-1:0] Racha,
  output logic [1:0]         o_estado
);

  localparam logic [SCORE_W+2:0] LP_BASE      = (SCORE_W+3)'(PUNTOS_BASE);
  localparam logic [RACHA_W-1:0] LP_PASO      = RACHA_W'(COMBO_PASO);
  localparam logic [2:0]         LP_MULT_MAX  = 3'(MULT_MAX);
  localparam logic [VIDAS_W-1:0] LP_VIDAS_INI = VIDAS_W'(VIDAS_INI);

  logic w_ev_ini, w_ev_hit, w_ev_miss;

  detector_flanco u_flanco_ini  (.clk(clk), .reset(reset), .i_in(Iniciar), .o_pulse(w_ev_ini));
  detector_flanco u_flanco_hit  (.clk(clk), .reset(reset), .i_in(Acierto), .o_pulse(w_ev_hit));
  detector_flanco u_flanco_miss (.clk(clk), .reset(reset), .i_in(Fallo),   .o_pulse(w_ev_miss));

  estado_t              r_estado;
  logic                 r_perdio;
  logic [SCORE_W-1:0]   r_puntaje;
  logic [VIDAS_W-1:0]   r_vidas;
  logic [2:0]           r_mult;
  logic [RACHA_W-1:0]   r_racha;

  estado_t              w_estado_sig;
  logic                 w_perdio_sig;
  logic [SCORE_W-1:0]   w_puntaje_sig;
  logic [VIDAS_W-1:0]   w_vidas_sig;
  logic [2:0]           w_mult_sig;
  logic [RACHA_W-1:0]   w_racha_sig;

  logic [SCORE_W+2:0]   w_suma;
  logic [SCORE_W-1:0]   w_puntaje_hit;
  logic [RACHA_W-1:0]   w_racha_hit;
  logic                 w_paso;
  logic [2:0]           w_mult_hit;
  logic [VIDAS_W-1:0]   w_vidas_miss;

  // The hit is scored with the multiplier in force before this hit can bump it.
  assign w_suma        = {3'b000, r_puntaje} + (LP_BASE * {{SCORE_W{1'b0}}, r_mult});
  assign w_puntaje_hit = (|w_suma[SCORE_W+2:SCORE_W]) ? {SCORE_W{1'b1}} : w_suma[SCORE_W-1:0];
  assign w_racha_hit   = (r_racha == RACHA_MAX) ? r_racha : r_racha + RACHA_W'(1);
  assign w_paso        = (w_racha_hit != '0) && ((w_racha_hit % LP_PASO) == '0);
  assign w_mult_hit    = (w_paso && (r_mult < LP_MULT_MAX)) ? r_mult + 3'd1 : r_mult;
  assign w_vidas_miss  = (r_vidas == '0) ? r_vidas : r_vidas - VIDAS_W'(1);

  always_comb begin
    w_estado_sig  = r_estado;
    w_perdio_sig  = r_perdio;
    w_puntaje_sig = r_puntaje;
    w_vidas_sig   = r_vidas;
    w_mult_sig    = r_mult;
    w_racha_sig   = r_racha;
    // A start edge wins over hit/miss in the same cycle, in every legal state.
    if (w_ev_ini && (r_estado == REPOSO || r_estado == JUGANDO || r_estado == PERDIDO)) begin
      w_estado_sig  = JUGANDO;
      w_perdio_sig  = 1'b0;
      w_puntaje_sig = '0;
      w_vidas_sig   = LP_VIDAS_INI;
      w_mult_sig    = 3'd1;
      w_racha_sig   = '0;
    end else begin
      case (r_estado)
        REPOSO:  ;
        JUGANDO: begin
          if (!Stop && w_ev_miss) begin
            w_racha_sig = '0;
            w_mult_sig  = 3'd1;
            w_vidas_sig = w_vidas_miss;
            if (w_vidas_miss == '0) begin
              w_estado_sig = PERDIDO;
              w_perdio_sig = 1'b1;
            end
          end else if (!Stop && w_ev_hit) begin
            w_puntaje_sig = w_puntaje_hit;
            w_racha_sig   = w_racha_hit;
            w_mult_sig    = w_mult_hit;
          end
        end
        PERDIDO: w_perdio_sig = 1'b1;
        default: w_estado_sig = REPOSO;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado  <= REPOSO;
      r_perdio  <= 1'b0;
      r_puntaje <= '0;
      r_vidas   <= LP_VIDAS_INI;
      r_mult    <= 3'd1;
      r_racha   <= '0;
    end else begin
      r_estado  <= w_estado_sig;
      r_perdio  <= w_perdio_sig;
      r_puntaje <= w_puntaje_sig;
      r_vidas   <= w_vidas_sig;
      r_mult    <= w_mult_sig;
      r_racha   <= w_racha_sig;
    end
  end

  assign Perdio   = r_perdio;
  assign Puntaje  = r_puntaje;
  assign Vidas    = r_vidas;
  assign Mult     = r_mult;
  assign Racha    = r_racha;
  assign o_estado = r_estado;

endmodule

// File: tb/tb_marcador_vidas.sv
// Bench for marcador_vidas: a game-rules model checked every cycle, plus literal spot values.
module tb_marcador_vidas;

  localparam int VI = 3;
  localparam int PB = 10;
  localparam int CP = 4;
  localparam int MM = 4;
  localparam int SMAX16 = 65535;
  localparam int SMAX8  = 255;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic Iniciar = 1'b0, Stop = 1'b0, Acierto = 1'b0, Fallo = 1'b0;

  logic        a_perdio, b_perdio;
  logic [15:0] a_puntaje;
  logic [7:0]  b_puntaje;
  logic [2:0]  a_vidas, b_vidas, a_mult, b_mult;
  logic [7:0]  a_racha, b_racha;
  logic [1:0]  a_estado, b_estado;

  marcador_vidas #(.VIDAS_INI(VI), .SCORE_W(16), .PUNTOS_BASE(PB), .COMBO_PASO(CP), .MULT_MAX(MM)) dut (
    .clk(clk), .reset(reset), .Iniciar(Iniciar), .Stop(Stop), .Acierto(Acierto), .Fallo(Fallo),
    .Perdio(a_perdio), .Puntaje(a_puntaje), .Vidas(a_vidas), .Mult(a_mult), .Racha(a_racha),
    .o_estado(a_estado)
  );

  marcador_vidas #(.VIDAS_INI(VI), .SCORE_W(8), .PUNTOS_BASE(PB), .COMBO_PASO(CP), .MULT_MAX(MM)) dut8 (
    .clk(clk), .reset(reset), .Iniciar(Iniciar), .Stop(Stop), .Acierto(Acierto), .Fallo(Fallo),
    .Perdio(b_perdio), .Puntaje(b_puntaje), .Vidas(b_vidas), .Mult(b_mult), .Racha(b_racha),
    .o_estado(b_estado)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // game-rules model: 0 idle, 1 playing, 2 lost
  int m_st, m_over, m_score, m_score8, m_vidas, m_mult, m_racha;
  bit p_i, p_a, p_f, q_i, q_a, q_f;
  bit m_valid = 1'b0;

  task automatic model_step();
    if (reset) begin
      m_st = 0; m_over = 0; m_score = 0; m_score8 = 0;
      m_vidas = VI; m_mult = 1; m_racha = 0;
      p_i = 0; p_a = 0; p_f = 0; q_i = 0; q_a = 0; q_f = 0;
      m_valid = 1'b1;
    end else begin
      // events seen at the previous edge take effect now
      if (p_i) begin
        m_st = 1; m_over = 0; m_score = 0; m_score8 = 0;
        m_vidas = VI; m_mult = 1; m_racha = 0;
      end else if (m_st == 1 && !Stop) begin
        if (p_f) begin
          m_racha = 0; m_mult = 1;
          if (m_vidas > 0) m_vidas--;
          if (m_vidas == 0) begin m_st = 2; m_over = 1; end
        end else if (p_a) begin
          m_score  = (m_score  + PB * m_mult > SMAX16) ? SMAX16 : m_score  + PB * m_mult;
          m_score8 = (m_score8 + PB * m_mult > SMAX8)  ? SMAX8  : m_score8 + PB * m_mult;
          m_racha  = (m_racha < 255) ? m_racha + 1 : 255;
          if (m_racha % CP == 0 && m_mult < MM) m_mult++;
        end
      end
      p_i = Iniciar && !q_i; p_a = Acierto && !q_a; p_f = Fallo && !q_f;
      q_i = Iniciar; q_a = Acierto; q_f = Fallo;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // scoreboard compare on the falling edge
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("perdio",   a_perdio,  m_over);
      chk("puntaje",  a_puntaje, m_score);
      chk("vidas",    a_vidas,   m_vidas);
      chk("mult",     a_mult,    m_mult);
      chk("racha",    a_racha,   m_racha);
      chk("estado",   a_estado,  m_st);
      chk("puntaje8", b_puntaje, m_score8);
      chk("perdio8",  b_perdio,  m_over);
      chk("vidas8",   b_vidas,   m_vidas);
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic hit();
    Acierto = 1'b1; tick(1); Acierto = 1'b0; tick(1);
  endtask

  task automatic miss();
    Fallo = 1'b1; tick(1); Fallo = 1'b0; tick(1);
  endtask

  task automatic start();
    Iniciar = 1'b1; tick(1); Iniciar = 1'b0; tick(1);
  endtask

  initial begin
    tick(3);
    chk("rst_puntaje", a_puntaje, 0);
    chk("rst_vidas",   a_vidas,   3);
    chk("rst_mult",    a_mult,    1);
    chk("rst_racha",   a_racha,   0);
    chk("rst_perdio",  a_perdio,  0);
    reset = 1'b0;
    tick(1);

    hit();
    chk("idle_hit_ignored", a_puntaje, 0);
    start();
    chk("started", a_estado, 1);

    repeat (3) hit();
    chk("t1_puntaje", a_puntaje, 30);
    chk("t1_racha",   a_racha,   3);
    chk("t1_mult",    a_mult,    1);
    chk("t1_perdio",  a_perdio,  0);

    start();
    Acierto = 1'b1; tick(20); Acierto = 1'b0; tick(1);
    chk("t2_held_puntaje", a_puntaje, 10);
    chk("t2_held_racha",   a_racha,   1);

    start();
    repeat (4) hit();
    chk("t3_mult4",  a_mult,    2);
    chk("t3_pts4",   a_puntaje, 40);
    repeat (4) hit();
    chk("t3_mult8",  a_mult,    3);
    chk("t3_pts8",   a_puntaje, 120);
    chk("t3_pts8_w8", b_puntaje, 120);
    repeat (5) hit();
    chk("sat_w16",   a_puntaje, 280);
    chk("sat_w8",    b_puntaje, 255);
    chk("mult_max",  a_mult,    4);
    repeat (3) hit();
    chk("mult_cap",  a_mult,    4);
    chk("pts16",     a_puntaje, 400);
    chk("racha16",   a_racha,   16);
    chk("sat_hold8", b_puntaje, 255);

    Acierto = 1'b1; Fallo = 1'b1; tick(1); Acierto = 1'b0; Fallo = 1'b0; tick(1);
    chk("t5_vidas",   a_vidas,   2);
    chk("t5_racha",   a_racha,   0);
    chk("t5_mult",    a_mult,    1);
    chk("t5_puntaje", a_puntaje, 400);

    Stop = 1'b1; hit(); miss(); Stop = 1'b0;
    chk("t6_stop_puntaje", a_puntaje, 400);
    chk("t6_stop_vidas",   a_vidas,   2);
    hit();
    chk("t6_after_stop", a_puntaje, 410);

    Iniciar = 1'b1; Acierto = 1'b1; tick(1); Iniciar = 1'b0; Acierto = 1'b0; tick(1);
    chk("restart_puntaje", a_puntaje, 0);
    chk("restart_racha",   a_racha,   0);
    chk("restart_vidas",   a_vidas,   3);

    repeat (2) hit();
    miss();
    chk("t4_v2", a_vidas, 2);
    miss();
    chk("t4_v1", a_vidas, 1);
    Fallo = 1'b1; tick(1); Fallo = 1'b0;
    chk("t4_perdio_early", a_perdio, 0);
    tick(1);
    chk("t4_perdio", a_perdio, 1);
    chk("t4_v0",     a_vidas,  0);
    miss();
    chk("t4_no_underflow", a_vidas, 0);
    hit();
    chk("lost_frozen", a_puntaje, 20);
    chk("lost_state",  a_estado,  2);

    start();
    chk("t6_perdio", a_perdio,  0);
    chk("t6_vidas",  a_vidas,   3);
    chk("t6_pts",    a_puntaje, 0);

    repeat (2) hit();
    reset = 1'b1; Iniciar = 1'b1; tick(1);
    chk("mid_rst_puntaje", a_puntaje, 0);
    chk("mid_rst_estado",  a_estado,  0);
    chk("mid_rst_vidas",   a_vidas,   3);
    reset = 1'b0; tick(1);
    chk("held_ini_wait", a_estado, 0);
    tick(1);
    chk("held_ini_edge", a_estado, 1);
    Iniciar = 1'b0;
    hit();
    chk("held_ini_hit", a_puntaje, 10);

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
